// File: rtl/csr_trap_seq.sv
// Trap/mret CSR write sequencer with a single registered CSR write port and PC redirect.
// Optional macro TRAP_BADADDR_EN adds the W_BAD step that writes mbadaddr.
module csr_trap_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_badaddr,
    input  logic        mret_req,
    input  logic        inst_csr_req,
    input  logic [11:0] inst_csr_adr,
    input  logic [31:0] inst_csr_wdata,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] csr_mtvec,
    output logic        csr_wr_en,
    output logic [11:0] csr_adr_wr,
    output logic [31:0] csr_wrdata,
    output logic        trap_ack,
    output logic        mret_ack,
    output logic        inst_csr_gnt,
    output logic        freeze,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [2:0]  dbg_state
);

    localparam logic [11:0] ADR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADR_MEPC     = 12'h341;
    localparam logic [11:0] ADR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADR_MBADADDR = 12'h343;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_MEPC  = 3'd1,
        W_CAUSE = 3'd2,
        W_BAD   = 3'd3,
        W_STAT  = 3'd4,
        REDIR   = 3'd5
    } state_t;

    // Handshake: a request is level-held by the requester until its one-cycle
    // ack/gnt pulse; it is only sampled in IDLE, so holding it across a busy
    // sequence simply defers it.
    state_t      state_q, state_d;
    logic        is_trap_q, is_trap_d;
    logic [31:0] cause_q, cause_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        trap_ack_q, trap_ack_d;
    logic        mret_ack_q, mret_ack_d;
    logic        gnt_q, gnt_d;
    logic        freeze_q, freeze_d;
    logic        redir_v_q, redir_v_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] trap_status, mret_status;

`ifdef TRAP_BADADDR_EN
    logic [31:0] bad_q, bad_d;
`else
    logic unused_badaddr;
    assign unused_badaddr = ^trap_badaddr;
`endif

    // Trap entry saves MIE into MPIE and forces M-mode in MPP; mret restores MIE.
    always_comb begin
        trap_status        = csr_mstatus;
        trap_status[7]     = csr_mstatus[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        mret_status        = csr_mstatus;
        mret_status[3]     = csr_mstatus[7];
        mret_status[7]     = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        is_trap_d  = is_trap_q;
        cause_d    = cause_q;
`ifdef TRAP_BADADDR_EN
        bad_d      = bad_q;
`endif
        wr_en_d    = 1'b0;
        adr_d      = 12'd0;
        wdata_d    = 32'd0;
        trap_ack_d = 1'b0;
        mret_ack_d = 1'b0;
        gnt_d      = 1'b0;
        redir_v_d  = 1'b0;
        redir_pc_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    state_d    = W_MEPC;
                    is_trap_d  = 1'b1;
                    cause_d    = trap_cause;
`ifdef TRAP_BADADDR_EN
                    bad_d      = trap_badaddr;
`endif
                    trap_ack_d = 1'b1;
                    wr_en_d    = 1'b1;
                    adr_d      = ADR_MEPC;
                    wdata_d    = trap_pc;
                end else if (mret_req) begin
                    state_d    = W_STAT;
                    is_trap_d  = 1'b0;
                    mret_ack_d = 1'b1;
                    wr_en_d    = 1'b1;
                    adr_d      = ADR_MSTATUS;
                    wdata_d    = mret_status;
                end else if (inst_csr_req) begin
                    gnt_d   = 1'b1;
                    wr_en_d = 1'b1;
                    adr_d   = inst_csr_adr;
                    wdata_d = inst_csr_wdata;
                end
            end
            W_MEPC: begin
                wr_en_d = 1'b1;
                adr_d   = ADR_MCAUSE;
                wdata_d = cause_q;
`ifdef TRAP_BADADDR_EN
                state_d = W_CAUSE;
`else
                state_d = W_CAUSE;
`endif
            end
            W_CAUSE: begin
                wr_en_d = 1'b1;
`ifdef TRAP_BADADDR_EN
                state_d = W_BAD;
                adr_d   = ADR_MBADADDR;
                wdata_d = bad_q;
`else
                state_d = W_STAT;
                adr_d   = ADR_MSTATUS;
                wdata_d = trap_status;
`endif
            end
            W_BAD: begin
                state_d = W_STAT;
                wr_en_d = 1'b1;
                adr_d   = ADR_MSTATUS;
                wdata_d = trap_status;
            end
            W_STAT: begin
                state_d    = REDIR;
                redir_v_d  = 1'b1;
                redir_pc_d = is_trap_q ? csr_mtvec : csr_mepc;
            end
            REDIR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        freeze_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_trap_q  <= 1'b0;
            cause_q    <= 32'd0;
`ifdef TRAP_BADADDR_EN
            bad_q      <= 32'd0;
`endif
            wr_en_q    <= 1'b0;
            adr_q      <= 12'd0;
            wdata_q    <= 32'd0;
            trap_ack_q <= 1'b0;
            mret_ack_q <= 1'b0;
            gnt_q      <= 1'b0;
            freeze_q   <= 1'b0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_trap_q  <= is_trap_d;
            cause_q    <= cause_d;
`ifdef TRAP_BADADDR_EN
            bad_q      <= bad_d;
`endif
            wr_en_q    <= wr_en_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            trap_ack_q <= trap_ack_d;
            mret_ack_q <= mret_ack_d;
            gnt_q      <= gnt_d;
            freeze_q   <= freeze_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign csr_wr_en      = wr_en_q;
    assign csr_adr_wr     = adr_q;
    assign csr_wrdata     = wdata_q;
    assign trap_ack       = trap_ack_q;
    assign mret_ack       = mret_ack_q;
    assign inst_csr_gnt   = gnt_q;
    assign freeze         = freeze_q;
    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq; follows TRAP_BADADDR_EN if the build defines it.
module tb_csr_trap_seq;

`ifdef TRAP_BADADDR_EN
    localparam int BAD = 1;
`else
    localparam int BAD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, mret_req, inst_csr_req;
    logic [31:0] trap_pc, trap_cause, trap_badaddr;
    logic [11:0] inst_csr_adr;
    logic [31:0] inst_csr_wdata, csr_mstatus, csr_mepc, csr_mtvec;
    logic        csr_wr_en, trap_ack, mret_ack, inst_csr_gnt, freeze, redirect_valid;
    logic [11:0] csr_adr_wr;
    logic [31:0] csr_wrdata, redirect_pc;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    csr_trap_seq dut (
        .clk(clk), .rst(rst),
        .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_badaddr(trap_badaddr),
        .mret_req(mret_req),
        .inst_csr_req(inst_csr_req), .inst_csr_adr(inst_csr_adr), .inst_csr_wdata(inst_csr_wdata),
        .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec),
        .csr_wr_en(csr_wr_en), .csr_adr_wr(csr_adr_wr), .csr_wrdata(csr_wrdata),
        .trap_ack(trap_ack), .mret_ack(mret_ack), .inst_csr_gnt(inst_csr_gnt),
        .freeze(freeze), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [11:0] adr, input logic [31:0] data);
        chk({tag, ".wr_en"}, {31'd0, csr_wr_en}, {31'd0, en});
        chk({tag, ".adr"}, {20'd0, csr_adr_wr}, {20'd0, adr});
        chk({tag, ".data"}, csr_wrdata, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        trap_req = 0; mret_req = 0; inst_csr_req = 0;
        trap_pc = 0; trap_cause = 0; trap_badaddr = 0;
        inst_csr_adr = 0; inst_csr_wdata = 0;
        csr_mstatus = 0; csr_mepc = 0; csr_mtvec = 0;
        step(); step();
        chk_wr("reset", 1'b0, 12'h000, 32'h0);
        chk("reset.freeze", {31'd0, freeze}, 32'd0);
        chk("reset.redir", {31'd0, redirect_valid}, 32'd0);
        chk("reset.state", {29'd0, dbg_state}, 32'd0);

        rst = 1'b1;
        step();
        chk_wr("post_rel", 1'b0, 12'h000, 32'h0);
        chk("post_rel.freeze", {31'd0, freeze}, 32'd0);

        // Trap with a simultaneous CSR-instruction write pending.
        csr_mstatus = 32'h8; csr_mtvec = 32'h40; csr_mepc = 32'h0;
        trap_pc = 32'h100; trap_cause = 32'h2; trap_badaddr = 32'hDEAD;
        trap_req = 1; inst_csr_req = 1; inst_csr_adr = 12'h305; inst_csr_wdata = 32'h80;
        step();
        chk("trap.ack", {31'd0, trap_ack}, 32'd1);
        chk("trap.gnt1", {31'd0, inst_csr_gnt}, 32'd0);
        chk("trap.freeze1", {31'd0, freeze}, 32'd1);
        chk_wr("trap.mepc", 1'b1, 12'h341, 32'h100);
        trap_req = 0;
        step();
        chk("trap.ack_pulse", {31'd0, trap_ack}, 32'd0);
        chk_wr("trap.mcause", 1'b1, 12'h342, 32'h2);
        if (BAD == 1) begin
            step();
            chk_wr("trap.mbad", 1'b1, 12'h343, 32'hDEAD);
        end
        step();
        chk_wr("trap.mstatus", 1'b1, 12'h300, 32'h1880);
        chk("trap.redir_early", {31'd0, redirect_valid}, 32'd0);
        step();
        chk_wr("trap.redir", 1'b0, 12'h000, 32'h0);
        chk("trap.redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("trap.redir_pc", redirect_pc, 32'h40);
        chk("trap.freeze_redir", {31'd0, freeze}, 32'd1);
        chk("trap.gnt_redir", {31'd0, inst_csr_gnt}, 32'd0);
        step();
        chk("trap.idle_freeze", {31'd0, freeze}, 32'd0);
        chk("trap.idle_redir", {31'd0, redirect_valid}, 32'd0);
        chk("trap.idle_gnt", {31'd0, inst_csr_gnt}, 32'd0);
        chk_wr("trap.idle", 1'b0, 12'h000, 32'h0);
        step();
        chk("inst.gnt", {31'd0, inst_csr_gnt}, 32'd1);
        chk_wr("inst.wr", 1'b1, 12'h305, 32'h80);
        chk("inst.freeze", {31'd0, freeze}, 32'd0);
        inst_csr_req = 0;
        step();
        chk("inst.gnt_off", {31'd0, inst_csr_gnt}, 32'd0);
        chk_wr("inst.off", 1'b0, 12'h000, 32'h0);

        // Mret.
        csr_mstatus = 32'h1880; csr_mepc = 32'h104;
        mret_req = 1;
        step();
        chk("mret.ack", {31'd0, mret_ack}, 32'd1);
        chk_wr("mret.mstatus", 1'b1, 12'h300, 32'h1888);
        chk("mret.freeze1", {31'd0, freeze}, 32'd1);
        mret_req = 0;
        step();
        chk("mret.redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("mret.redir_pc", redirect_pc, 32'h104);
        chk("mret.freeze2", {31'd0, freeze}, 32'd1);
        chk_wr("mret.redir", 1'b0, 12'h000, 32'h0);
        step();
        chk("mret.idle_freeze", {31'd0, freeze}, 32'd0);
        chk("mret.idle_redir", {31'd0, redirect_valid}, 32'd0);

        // Back-to-back CSR-instruction writes.
        inst_csr_req = 1; inst_csr_adr = 12'h340; inst_csr_wdata = 32'h11;
        step();
        chk_wr("b2b0", 1'b1, 12'h340, 32'h11);
        chk("b2b0.gnt", {31'd0, inst_csr_gnt}, 32'd1);
        inst_csr_wdata = 32'h22;
        step();
        chk_wr("b2b1", 1'b1, 12'h340, 32'h22);
        chk("b2b1.gnt", {31'd0, inst_csr_gnt}, 32'd1);
        chk("b2b1.freeze", {31'd0, freeze}, 32'd0);
        inst_csr_wdata = 32'h33;
        step();
        chk_wr("b2b2", 1'b1, 12'h340, 32'h33);
        chk("b2b2.gnt", {31'd0, inst_csr_gnt}, 32'd1);
        inst_csr_req = 0;
        step();
        chk("b2b.gnt_off", {31'd0, inst_csr_gnt}, 32'd0);
        chk("b2b.wr_off", {31'd0, csr_wr_en}, 32'd0);

        // Trap beats mret; reset lands mid-sequence with both requests held.
        csr_mstatus = 32'h0; csr_mtvec = 32'h80; csr_mepc = 32'h200;
        trap_pc = 32'h200; trap_cause = 32'h5; trap_badaddr = 32'hBEEF;
        trap_req = 1; mret_req = 1;
        step();
        chk("prio.trap_ack", {31'd0, trap_ack}, 32'd1);
        chk("prio.mret_ack", {31'd0, mret_ack}, 32'd0);
        step();
        chk_wr("rst.mcause", 1'b1, 12'h342, 32'h5);
        rst = 1'b0;
        step();
        chk("rst.state", {29'd0, dbg_state}, 32'd0);
        chk("rst.freeze", {31'd0, freeze}, 32'd0);
        chk_wr("rst.wr", 1'b0, 12'h000, 32'h0);
        rst = 1'b1;
        step();
        chk("restart.ack", {31'd0, trap_ack}, 32'd1);
        chk_wr("restart.mepc", 1'b1, 12'h341, 32'h200);
        trap_req = 0;
        n = 1;
        while (mret_ack !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("pend.mret_ack", {31'd0, mret_ack}, 32'd1);
        chk("pend.mret_cycle", n, 6 + BAD);
        chk_wr("pend.mstatus", 1'b1, 12'h300, 32'h80);
        mret_req = 0;
        step();
        chk("pend.redir_pc", redirect_pc, 32'h200);
        step();
        chk("pend.idle", {31'd0, freeze}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_trap_seq.md
CSR_TRAP_SEQ -- requirements
Module: csr_trap_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  synchronous reset, active-low (0 = reset).
REQ-003 SHALL have: trap_req  in  1, trap_pc  in  32, trap_cause  in  32, trap_badaddr  in  32  (trap request and payload, held until trap_ack).
REQ-004 SHALL have: mret_req  in  1  (mret request, held until mret_ack).
REQ-005 SHALL have: inst_csr_req  in  1, inst_csr_adr  in  12, inst_csr_wdata  in  32  (CSR-instruction write, held until inst_csr_gnt).
REQ-006 SHALL have: csr_mstatus  in  32, csr_mepc  in  32, csr_mtvec  in  32  (current CSR values).
REQ-007 SHALL have: csr_wr_en  out  1, csr_adr_wr  out  12, csr_wrdata  out  32  (single CSR write port, registered).
REQ-008 SHALL have: trap_ack, mret_ack, inst_csr_gnt  out  1 each  (one-cycle pulses).
REQ-009 SHALL have: freeze  out  1  (pipeline stall), redirect_valid  out  1, redirect_pc  out  32.

Function
REQ-010 SHALL implement FSM states IDLE, W_MEPC, W_CAUSE, W_BAD, W_STAT, REDIR; all outputs registered.
REQ-011 In IDLE, priority SHALL be trap_req > mret_req > inst_csr_req; the loser SHALL stay pending (no ack/gnt).
REQ-012 Trap accepted in IDLE at cycle T: payload latched; trap_ack=1 at T+1; sequence W_MEPC(T+1), W_CAUSE(T+2), W_BAD(T+3), W_STAT(T+4), REDIR(T+5), IDLE(T+6).
REQ-013 W_MEPC SHALL drive csr_wr_en=1, adr `mepc, data latched trap_pc.
REQ-014 W_CAUSE SHALL write `mcause with latched trap_cause; W_BAD SHALL write `mbadaddr with latched trap_badaddr.
REQ-015 W_STAT on trap SHALL write `mstatus = csr_mstatus with bit7 (MPIE) = bit3 (MIE), bit3 = 0, bits 12:11 = 2'b11.
REQ-016 Mret accepted in IDLE at T: mret_ack=1 at T+1; W_STAT(T+1) writes `mstatus with bit3 = bit7, bit7 = 1; REDIR(T+2); IDLE(T+3).
REQ-017 REDIR SHALL drive redirect_valid=1 for exactly one cycle, redirect_pc = csr_mtvec (trap) or csr_mepc (mret) sampled at REDIR entry, csr_wr_en=0.
REQ-018 freeze SHALL be 1 in every non-IDLE state, including REDIR, and 0 in IDLE.
REQ-019 Inst write accepted in IDLE at T (no trap/mret): at T+1 csr_wr_en=1, csr_adr_wr=inst_csr_adr, csr_wrdata=inst_csr_wdata, inst_csr_gnt=1; FSM stays IDLE; back-to-back grants allowed every cycle.
REQ-020 Requests arriving in non-IDLE states SHALL be ignored until IDLE; no request SHALL be dropped while held.
REQ-021 csr_wr_en SHALL be 0 whenever no write state or grant is active; csr_adr_wr/csr_wrdata SHALL be 0 when csr_wr_en=0.
REQ-022 A trap_req and inst_csr_req asserted in the same IDLE cycle SHALL yield the trap sequence first; the inst write is granted in the first IDLE cycle after the sequence.

Reset
REQ-023 rst=0 at a clock edge SHALL force IDLE and all outputs to 0, including mid-sequence; no partial CSR write SHALL occur on the cycle after reset release.
REQ-024 Latched payload registers SHALL reset to 0.

Configuration
REQ-025 Macro TRAP_BADADDR_EN: when defined, W_BAD is included as in REQ-012.
REQ-026 When TRAP_BADADDR_EN is undefined, W_BAD SHALL be skipped (W_CAUSE -> W_STAT), `mbadaddr is never written, trap_badaddr is unused, and trap REDIR occurs at T+4.

Verification
REQ-027 Trap trap_pc=0x100, cause=0x2, badaddr=0xDEAD, mstatus=0x8, mtvec=0x40 -> writes mepc=0x100, mcause=0x2, mbadaddr=0xDEAD, mstatus=0x1880 on T+1..T+4; redirect_pc=0x40 at T+5.
REQ-028 Mret with mstatus=0x1880, mepc=0x104 -> mstatus write 0x1888 at T+1, redirect_pc=0x104 at T+2, freeze 1 for 2 cycles.
REQ-029 Simultaneous trap_req and inst_csr_req (adr 0x305, data 0x80) -> trap sequence first, inst write 0x305/0x80 with gnt at T+7.
REQ-030 inst_csr_req held 3 cycles with distinct data each handshake -> three consecutive writes, no freeze.
REQ-031 rst=0 asserted during W_CAUSE -> next cycle IDLE, csr_wr_en=0, freeze=0; held trap_req restarts the full sequence after release.
REQ-032 Build without TRAP_BADADDR_EN -> no `mbadaddr write, redirect_valid at T+4.
